bus_bridge: RTL and testbench

- Memory-mapped bus bridge directly downstream of the pipelined CPU's MEM stage; consumes Bus_addr/Bus_wen/Bus_wdata and returns Bus_rdata in the same cycle.
- Routes each access to the data RAM or to on-chip I/O.
- On-chip I/O: LED register, switch and button inputs, 7-segment scan driver, free-running timer.
- Sequential content: peripheral registers, input synchronisers, display scan counter and timer prescaler.

---
 rtl/bus_bridge.sv | 154 +++++++++++++++
 tb/tb_bus_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_bridge.sv
// Memory-mapped bridge between the CPU MEM stage and data RAM / on-chip I/O
// (LEDs, switches, buttons, 7-segment scan driver, prescaled timer).
module bus_bridge #(
   parameter int DRAM_AW  = 14,
   parameter int SCAN_DIV = 20000
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   input  logic [31:0]        Bus_addr,
   input  logic               Bus_wen,
   input  logic [31:0]        Bus_wdata,
   output logic [31:0]        Bus_rdata,
   output logic [DRAM_AW-1:0] dram_addr,
   output logic               dram_wen,
   output logic [31:0]        dram_wdata,
   input  logic [31:0]        dram_rdata,
   input  logic [23:0]        sw,
   input  logic [4:0]         button,
   output logic [23:0]        led,
   output logic [7:0]         dig_en,
   output logic [7:0]         seg
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

   // Word offsets within the 4 KiB I/O page
   localparam logic [9:0] OFF_SEG  = 10'h000;
   localparam logic [9:0] OFF_TCNT = 10'h008;
   localparam logic [9:0] OFF_TDIV = 10'h009;
   localparam logic [9:0] OFF_LED  = 10'h018;
   localparam logic [9:0] OFF_SW   = 10'h01C;
   localparam logic [9:0] OFF_BTN  = 10'h01E;

   logic              is_io;
   logic [9:0]        word;
   logic              io_wr;
   logic [31:0]       seg_reg;
   logic [31:0]       tcnt;
   logic [31:0]       tdiv;
   logic [31:0]       presc;
   logic              tick;
   logic [23:0]       sw_s1, sw_s2;
   logic [4:0]        btn_s1, btn_s2;
   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        idx;
   logic [3:0]        nib;
   logic              unused_addr;

   assign is_io       = (Bus_addr[31:12] == 20'hFFFFF);
   assign word        = Bus_addr[11:2];
   assign io_wr       = Bus_wen & is_io;
   assign unused_addr = ^Bus_addr[1:0];

   assign dram_addr  = Bus_addr[DRAM_AW+1:2];
   assign dram_wen   = Bus_wen & ~is_io;
   assign dram_wdata = Bus_wdata;

   always_comb begin
      Bus_rdata = 32'h0;
      if (!is_io) begin
         Bus_rdata = dram_rdata;
      end else begin
         case (word)
            OFF_SEG:  Bus_rdata = seg_reg;
            OFF_TCNT: Bus_rdata = tcnt;
            OFF_TDIV: Bus_rdata = tdiv;
            OFF_LED:  Bus_rdata = {8'h0, led};
            OFF_SW:   Bus_rdata = {8'h0, sw_s2};
            OFF_BTN:  Bus_rdata = {27'h0, btn_s2};
            default:  Bus_rdata = 32'h0;
         endcase
      end
   end

   // Peripheral registers and input synchronisers
   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         seg_reg <= 32'h0;
         led     <= 24'h0;
         sw_s1   <= 24'h0;
         sw_s2   <= 24'h0;
         btn_s1  <= 5'h0;
         btn_s2  <= 5'h0;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         btn_s1 <= button;
         btn_s2 <= btn_s1;
         if (io_wr && word == OFF_SEG) seg_reg <= Bus_wdata;
         if (io_wr && word == OFF_LED) led     <= Bus_wdata[23:0];
      end
   end

   // Timer: a TCNT write takes priority over a coincident tick
   assign tick = (tdiv != 32'h0) && (presc == tdiv - 32'd1);

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         tcnt  <= 32'h0;
         tdiv  <= 32'h0;
         presc <= 32'h0;
      end else begin
         if (io_wr && word == OFF_TCNT) tcnt <= Bus_wdata;
         else if (tick)                 tcnt <= tcnt + 32'd1;

         if (io_wr && word == OFF_TDIV) tdiv <= Bus_wdata;

         if (io_wr && (word == OFF_TCNT || word == OFF_TDIV)) presc <= 32'h0;
         else if (tick)                                      presc <= 32'h0;
         else if (tdiv != 32'h0)                             presc <= presc + 32'd1;
      end
   end

   // Display scan
   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         scan_cnt <= '0;
         idx      <= 3'd0;
      end else if (scan_cnt == SCAN_MAX) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign nib    = seg_reg[{idx, 2'b00} +: 4];
   assign dig_en = ~(8'b1 << idx);

   always_comb begin
      seg = 8'hFF;
      case (nib)
         4'h0: seg = 8'h03;
         4'h1: seg = 8'h9F;
         4'h2: seg = 8'h25;
         4'h3: seg = 8'h0D;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h49;
         4'h6: seg = 8'h41;
         4'h7: seg = 8'h1F;
         4'h8: seg = 8'h01;
         4'h9: seg = 8'h09;
         4'hA: seg = 8'h11;
         4'hB: seg = 8'hC1;
         4'hC: seg = 8'h63;
         4'hD: seg = 8'h85;
         4'hE: seg = 8'h61;
         4'hF: seg = 8'h71;
         default: seg = 8'hFF;
      endcase
   end

endmodule

// File: tb/tb_bus_bridge.sv
// Scoreboard bench for bus_bridge: stimulus queues expectations, monitor compares on each sample.
module tb_bus_bridge;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [31:0] Bus_addr, Bus_wdata, Bus_rdata, dram_wdata, dram_rdata;
   logic        Bus_wen, dram_wen;
   logic [13:0] dram_addr;
   logic [23:0] sw, led;
   logic [4:0]  button;
   logic [7:0]  dig_en, seg;

   int checks = 0;
   int failures = 0;

   string       qn[$];
   int          qk[$];
   logic [31:0] qe[$];
   event        smp;

   localparam int K_RDATA = 0, K_LED = 1, K_DIG = 2, K_SEG = 3,
                  K_DWEN = 4, K_DADDR = 5, K_DWDATA = 6;

   bus_bridge #(.DRAM_AW(14), .SCAN_DIV(4)) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata),
      .Bus_rdata(Bus_rdata),
      .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata),
      .dram_rdata(dram_rdata),
      .sw(sw), .button(button), .led(led), .dig_en(dig_en), .seg(seg)
   );

   always #5 cpu_clk = ~cpu_clk;

   function automatic logic [31:0] act(input int k);
      case (k)
         K_RDATA:  return Bus_rdata;
         K_LED:    return {8'h0, led};
         K_DIG:    return {24'h0, dig_en};
         K_SEG:    return {24'h0, seg};
         K_DWEN:   return {31'h0, dram_wen};
         K_DADDR:  return {18'h0, dram_addr};
         K_DWDATA: return dram_wdata;
         default:  return 32'hX;
      endcase
   endfunction

   // Monitor: drains the expectation queue whenever the outputs are sampled
   initial begin
      forever begin
         @(smp);
         while (qk.size() > 0) begin
            automatic string       n = qn.pop_front();
            automatic int          k = qk.pop_front();
            automatic logic [31:0] e = qe.pop_front();
            automatic logic [31:0] a = act(k);
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL %s: got %h expected %h", n, a, e);
            end
         end
      end
   end

   task automatic expect_v(input string n, input int k, input logic [31:0] e);
      qn.push_back(n); qk.push_back(k); qe.push_back(e);
   endtask

   task automatic sample();
      #1 -> smp;
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge cpu_clk);
      #1;
   endtask

   task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d);
      Bus_addr = a; Bus_wen = w; Bus_wdata = d;
   endtask

   initial begin
      cpu_rst = 1'b0;
      bus(32'h0, 1'b0, 32'h0);
      dram_rdata = 32'h0; sw = 24'h0; button = 5'h0;

      // Reset state
      step(2);
      expect_v("rst_dig_en", K_DIG, 32'hFE);
      expect_v("rst_seg", K_SEG, 32'h03);
      expect_v("rst_led", K_LED, 32'h0);
      sample();
      cpu_rst = 1'b1;

      // DRAM passthrough
      step(1);
      bus(32'h0000_0104, 1'b1, 32'hDEADBEEF);
      expect_v("dram_wen", K_DWEN, 32'h1);
      expect_v("dram_addr", K_DADDR, 32'h041);
      expect_v("dram_wdata", K_DWDATA, 32'hDEADBEEF);
      sample();
      Bus_wen = 1'b0; dram_rdata = 32'h12345678;
      expect_v("dram_rdata", K_RDATA, 32'h12345678);
      sample();

      // LED write / readback, RO and unmapped writes ignored
      bus(32'hFFFFF060, 1'b1, 32'hFFA5A5A5);
      expect_v("led_dram_wen", K_DWEN, 32'h0);
      expect_v("led_pre_edge", K_LED, 32'h0);
      sample();
      step(1);
      Bus_wen = 1'b0;
      expect_v("led_out", K_LED, 32'hA5A5A5);
      expect_v("led_read", K_RDATA, 32'h00A5A5A5);
      sample();
      bus(32'hFFFFF070, 1'b1, 32'h12345678);
      step(1);
      bus(32'hFFFFF100, 1'b1, 32'h87654321);
      step(1);
      bus(32'hFFFFF070, 1'b0, 32'h0);
      expect_v("sw_ro_write", K_RDATA, 32'h0);
      expect_v("led_after_ro", K_LED, 32'hA5A5A5);
      sample();
      Bus_addr = 32'hFFFFF100;
      expect_v("unmapped_read", K_RDATA, 32'h0);
      sample();

      // Switch / button synchronisers
      Bus_addr = 32'hFFFFF070; sw = 24'h00F00F;
      expect_v("sw_edge0", K_RDATA, 32'h0);
      sample();
      step(1);
      expect_v("sw_edge1", K_RDATA, 32'h0);
      sample();
      step(1);
      expect_v("sw_edge2", K_RDATA, 32'h0000F00F);
      sample();
      Bus_addr = 32'hFFFFF078; button = 5'h15;
      step(1);
      expect_v("btn_edge1", K_RDATA, 32'h0);
      sample();
      step(1);
      expect_v("btn_edge2", K_RDATA, 32'h15);
      sample();

      // Scan: fresh reset so idx/scan_cnt start from zero
      cpu_rst = 1'b0; #1 cpu_rst = 1'b1;
      bus(32'hFFFFF000, 1'b1, 32'h0000_00F1);
      step(1);
      Bus_wen = 1'b0;
      expect_v("scan0_seg", K_SEG, 32'h9F);
      expect_v("scan0_dig", K_DIG, 32'hFE);
      expect_v("seg_read", K_RDATA, 32'hF1);
      sample();
      step(3);
      expect_v("scan1_seg", K_SEG, 32'h71);
      expect_v("scan1_dig", K_DIG, 32'hFD);
      sample();
      step(27);
      expect_v("scan7_seg", K_SEG, 32'h03);
      expect_v("scan7_dig", K_DIG, 32'h7F);
      sample();
      step(1);
      expect_v("scanwrap_seg", K_SEG, 32'h9F);
      expect_v("scanwrap_dig", K_DIG, 32'hFE);
      sample();

      // Timer
      bus(32'hFFFFF024, 1'b1, 32'd3);
      step(1);
      bus(32'hFFFFF020, 1'b1, 32'hFFFFFFFE);
      step(1);
      Bus_wen = 1'b0;
      step(2);
      expect_v("tcnt_2", K_RDATA, 32'hFFFFFFFE);
      sample();
      step(1);
      expect_v("tcnt_3", K_RDATA, 32'hFFFFFFFF);
      sample();
      step(3);
      expect_v("tcnt_wrap", K_RDATA, 32'h0);
      sample();
      step(2);
      bus(32'hFFFFF020, 1'b1, 32'd5);
      step(1);
      Bus_wen = 1'b0;
      expect_v("tcnt_write_wins", K_RDATA, 32'd5);
      sample();
      bus(32'hFFFFF024, 1'b1, 32'd0);
      step(1);
      bus(32'hFFFFF020, 1'b0, 32'h0);
      step(10);
      expect_v("tcnt_frozen", K_RDATA, 32'd5);
      sample();

      // Asynchronous reset mid-cycle, no clock edge
      cpu_rst = 1'b0;
      expect_v("arst_led", K_LED, 32'h0);
      expect_v("arst_tcnt", K_RDATA, 32'h0);
      expect_v("arst_dig", K_DIG, 32'hFE);
      expect_v("arst_seg", K_SEG, 32'h03);
      sample();
      Bus_addr = 32'h0000_0008; dram_rdata = 32'hCAFEF00D;
      expect_v("arst_dram_pass", K_RDATA, 32'hCAFEF00D);
      expect_v("arst_dram_addr", K_DADDR, 32'h002);
      sample();

      #5;
      if (qk.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", qk.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
